// File: rtl/block_dispatcher.sv
// Kernel block scheduler: splits a launch of thread_count threads into fixed-size
// blocks and hands them out one at a time to a shared pool of compute cores.
module block_dispatcher #(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned THREAD_CNT_BITS   = 8
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic [THREAD_CNT_BITS-1:0]                            thread_count,
  input  logic [NUM_CORES-1:0]                                  core_done,
  output logic [NUM_CORES-1:0]                                  core_start,
  output logic [NUM_CORES-1:0]                                  core_reset,
  output logic [NUM_CORES-1:0][THREAD_CNT_BITS-1:0]             core_block_id,
  output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0]     core_thread_count,
  output logic                                                  done
);

  localparam int unsigned TPB_LOG = $clog2(THREADS_PER_BLOCK);
  localparam int unsigned CTW     = TPB_LOG + 1;
  localparam int unsigned BW      = THREAD_CNT_BITS + 1;
  localparam int unsigned RW      = BW + TPB_LOG;
  localparam int unsigned IW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state;
  logic [THREAD_CNT_BITS-1:0] tc_latched;
  logic [BW-1:0]              total_blocks;
  logic [BW-1:0]              blocks_dispatched;
  logic [BW-1:0]              blocks_done;

  logic [NUM_CORES-1:0]       completing_c;
  logic [NUM_CORES-1:0]       free_c;
  logic [BW-1:0]              done_inc_c;
  logic [IW-1:0]              disp_idx_c;
  logic                       disp_ok_c;
  logic [RW-1:0]              remaining_c;
  logic [CTW-1:0]             block_threads_c;

  // Completion mask, popcount, lowest free core and the size of the next block.
  always_comb begin
    completing_c = core_start & core_done;
    free_c       = ~core_start & ~core_reset;
    done_inc_c   = '0;
    disp_idx_c   = '0;
    disp_ok_c    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_inc_c = done_inc_c + BW'(completing_c[i]);
      if (free_c[i] && !disp_ok_c) begin
        disp_idx_c = IW'(i);
        disp_ok_c  = 1'b1;
      end
    end
    remaining_c     = RW'(tc_latched) - (RW'(blocks_dispatched) << TPB_LOG);
    block_threads_c = (remaining_c >= RW'(THREADS_PER_BLOCK)) ? CTW'(THREADS_PER_BLOCK)
                                                              : CTW'(remaining_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      tc_latched        <= '0;
      total_blocks      <= '0;
      blocks_dispatched <= '0;
      blocks_done       <= '0;
      core_start        <= '0;
      core_reset        <= '0;
      core_block_id     <= '0;
      core_thread_count <= '0;
      done              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tc_latched        <= thread_count;
            total_blocks      <= BW'((BW'(thread_count) + BW'(THREADS_PER_BLOCK - 1)) >> TPB_LOG);
            blocks_dispatched <= '0;
            blocks_done       <= '0;
            core_start        <= '0;
            core_reset        <= '1;
            done              <= 1'b0;
            state             <= RUN;
          end
        end
        RUN: begin
          // Retirement check wins over any dispatch on the same edge.
          if (blocks_done == total_blocks) begin
            done       <= 1'b1;
            core_start <= '0;
            core_reset <= '0;
            state      <= DONE;
          end else begin
            // Completing cores get a one-cycle reset; every other reset releases.
            core_reset  <= completing_c;
            blocks_done <= blocks_done + done_inc_c;
            if (disp_ok_c && (blocks_dispatched < total_blocks)) begin
              core_start                    <= (core_start & ~completing_c)
                                               | (NUM_CORES'(1) << disp_idx_c);
              core_block_id[disp_idx_c]     <= THREAD_CNT_BITS'(blocks_dispatched);
              core_thread_count[disp_idx_c] <= block_threads_c;
              blocks_dispatched             <= blocks_dispatched + BW'(1);
            end else begin
              core_start <= core_start & ~completing_c;
            end
          end
        end
        DONE: begin
          core_start <= '0;
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/block_dispatcher.md
Name: block_dispatcher

Overview:
- Kernel-level scheduler that divides a launch of thread_count threads into blocks of THREADS_PER_BLOCK threads.
- Shares the NUM_CORES compute cores among those blocks: hands out blocks one at a time, resets each core between blocks, and counts completions.
- Sits between the device control registers (start, thread_count) and the core array; asserts done when every block has retired.

Parameters:
- NUM_CORES, 2, number of cores sharing the block queue (at least 1).
- THREADS_PER_BLOCK, 4, threads per block; must be a power of two, at least 1.
- THREAD_CNT_BITS, 8, width of thread_count and of block ids.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  launch request, level-sensitive.
- thread_count  input  THREAD_CNT_BITS  total threads in the kernel; sampled at launch.
- core_done  input  NUM_CORES  per-core block-complete flag; level.
- core_start  output  NUM_CORES  per-core run enable; held for the whole block.
- core_reset  output  NUM_CORES  per-core reset pulse between blocks.
- core_block_id  output  NUM_CORES x THREAD_CNT_BITS  block index assigned to each core.
- core_thread_count  output  NUM_CORES x ($clog2(THREADS_PER_BLOCK)+1)  live threads in the assigned block.
- done  output  1  kernel complete.

Behaviour:
- Clocking and reset: single clock domain, clk. Reset is synchronous and active-high on reset. On reset, all outputs go to 0, the FSM goes to IDLE and all counters clear. Reset asserted mid-run aborts the kernel; all outputs are 0 after the next edge.
- Global FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch total_blocks = (thread_count + THREADS_PER_BLOCK-1) / THREADS_PER_BLOCK, computed at THREAD_CNT_BITS+1 width so there is no overflow (255 threads gives 64 blocks with TPB=4);
  - clear blocks_dispatched and blocks_done;
  - drive core_reset to all ones for one cycle;
  - go to RUN.
- RUN, on each edge, evaluated in this order:
  1. If blocks_done == total_blocks: done<=1, go to DONE. This check precedes dispatch.
  2. Completion: for each core i with core_start[i]=1 and core_done[i]=1:
     - core_start[i]<=0, core_reset[i]<=1;
     - blocks_done increments by the number of completing cores this edge (popcount; simultaneous completions all count).
  3. Reset release: any core with core_reset[i]=1 that is not completing this edge gets core_reset[i]<=0.
  4. Dispatch: a core is free when its registered core_start=0 and core_reset=0. If blocks_dispatched < total_blocks, the lowest-index free core i gets:
     - core_start[i]<=1;
     - core_block_id[i]<=blocks_dispatched;
     - core_thread_count[i]<=min(THREADS_PER_BLOCK, thread_count_latched - blocks_dispatched*THREADS_PER_BLOCK);
     - blocks_dispatched increments.
     At most one dispatch per edge.
- RUN, ignored inputs: core_done on a core with core_start=0 is ignored. start is ignored while in RUN.
- DONE:
  - done held at 1 and all core_start at 0;
  - on an edge with start=0: done<=0, go to IDLE.
- Block id and thread count hold their last values after core_start drops.
- Timing from the start-sampling edge E0:
  - core_reset all high after E0;
  - first core_start[0] after E0+2 (E0+1 releases the reset);
  - the second core starts after E0+3.
- A freed core is reset for exactly one cycle, becomes eligible at the following edge, and so starts a new block no earlier than 2 edges after its core_done is sampled.
- thread_count=0: total_blocks=0, no core_start is ever asserted, and done=1 after E0+1.
- Remainder: only the final block may have core_thread_count < THREADS_PER_BLOCK.

Test Plan:
- Reset: assert reset for 2 cycles during RUN -> done=0, core_start=0, core_reset=0, all ids and counts 0; the FSM re-launches cleanly afterwards.
- Even split (NUM_CORES=2, TPB=4), thread_count=8, start at E0 -> core_reset=2'b11 after E0; core_start[0]=1, id 0, count 4 after E0+2; core_start[1]=1, id 1, count 4 after E0+3. Raise both core_done -> done=1 one edge after blocks_done reaches 2.
- Remainder and reuse, thread_count=10 -> blocks 0 and 1 get 4 threads, block 2 gets 2. Drop core 1 done first -> block 2 goes to core 1 two edges after its done is sampled, preceded by a one-cycle core_reset[1].
- Zero threads, thread_count=0 -> done=1 after E0+1; core_start stays 0 throughout; deassert start -> done=0 and back to IDLE.
- Simultaneous completion, with 4 blocks and both cores finishing on the same edge -> blocks_done +2; both core_reset high for one cycle; blocks 2 and 3 dispatched on consecutive edges, lowest core first.
- Spurious and ignored inputs: core_done[1]=1 while core 1 is idle -> no count change; toggle start during RUN -> no effect; hold start high in DONE -> done stays 1.
